// File: rtl/imem_port_if.sv
// imem_port_if
//   Bundles the fetch port, the loader/debug port and the program-memory port
//   of the instruction-memory arbiter.
//   Fetch  : f_req, f_addr -> f_gnt, f_rvalid, f_rdata
//   Loader : l_req, l_we, l_lock, l_addr, l_wdata -> l_gnt, l_rvalid, l_rdata
//   Core   : cpu_stall (high while the loader owns the memory exclusively)
//   Memory : mem_we, mem_addr, mem_di -> memory; mem_dout <- memory (1-cycle latency)
//   Modports: slave = arbiter side, master = requesters/memory side.
interface imem_port_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 20
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              l_req;
  logic              l_we;
  logic              l_lock;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  logic              cpu_stall;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_di;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_dout,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, cpu_stall,
           mem_we, mem_addr, mem_di
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_dout,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, cpu_stall,
           mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares the single-port program memory between the CPU fetch unit and the
//   program loader/debug port. Fetch wins by default; the loader is forced ahead
//   after MAX_WAIT denied cycles, or takes exclusive ownership with l_lock, which
//   stalls the CPU until the lock is dropped. Read data is routed back using a
//   registered owner tag, one cycle after the grant.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     bus.slave : fetch, loader, cpu_stall and memory signals (see imem_port_if)
module imem_port_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 20,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  imem_port_if.slave  bus
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t              state;
  logic                stall_q;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                f_vld_p1;
  logic                l_vld_p1;

  logic                starved;
  logic                f_gnt_c;
  logic                l_gnt_c;

  // Grants are withheld while reset is asserted so the memory sees no access.
  always_comb begin
    starved = (wait_cnt == WCNT_W'(MAX_WAIT));
    f_gnt_c = 1'b0;
    l_gnt_c = 1'b0;
    if (!rst) begin
      if (state == LOCKED) begin
        l_gnt_c = bus.l_req;
      end else begin
        l_gnt_c = bus.l_req & (~bus.f_req | starved);
        f_gnt_c = bus.f_req & ~l_gnt_c;
      end
    end
  end

  assign bus.f_gnt    = f_gnt_c;
  assign bus.l_gnt    = l_gnt_c;
  assign bus.mem_we   = l_gnt_c & bus.l_we;
  assign bus.mem_addr = l_gnt_c ? bus.l_addr : bus.f_addr;
  assign bus.mem_di   = bus.l_wdata;

  // Stage p0 -> p1: memory access issued, owner tag registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      stall_q  <= 1'b0;
      wait_cnt <= '0;
      f_vld_p1 <= 1'b0;
      l_vld_p1 <= 1'b0;
    end else begin
      f_vld_p1 <= f_gnt_c;
      l_vld_p1 <= l_gnt_c & ~bus.l_we;

      if (bus.l_req && !l_gnt_c) begin
        if (!starved) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        ARB: begin
          if (l_gnt_c && bus.l_lock) begin
            state   <= LOCKED;
            stall_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (!bus.l_lock) begin
            state   <= ARB;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state   <= ARB;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: read data returns from memory. A reset in this cycle cancels
  // any tagged return so no stale data is presented during reset.
  assign bus.f_rvalid  = f_vld_p1 & ~rst;
  assign bus.l_rvalid  = l_vld_p1 & ~rst;
  assign bus.f_rdata   = bus.mem_dout;
  assign bus.l_rdata   = bus.mem_dout;
  assign bus.cpu_stall = stall_q & ~rst;

endmodule
